wave_param_loader: RTL
======================

# wave_param_loader

Sequencer and arbiter that sits between the three parameter pipe endpoints (amp 0x80, offset 0x81, phaseword 0x82) and the 64-channel synthesis bank. It shares one single-write-port 192x16 shadow store between the three pipe streams through a round-robin arbiter. On a commit request it drains pending words and copies the shadow store word-by-word into the active 1024-bit parameter buses that drive the bank.

## Interface
Parameters: none; geometry is fixed at 3 channels x 64 words x 16 bits.

- clk  in  1  ti_clk domain; all state is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- amp_write  in  1  amp pipe strobe; one word per high cycle.
- amp_data  in  16  amp pipe word.
- offset_write  in  1  offset pipe strobe.
- offset_data  in  16  offset pipe word.
- phase_write  in  1  phaseword pipe strobe.
- phase_data  in  16  phaseword pipe word.
- commit  in  1  level; sampled only in IDLE.
- amps  out  1024  active amplitudes; word k at [16k+15:16k].
- offsets  out  1024  active offsets; same packing.
- phasewords  out  1024  active phasewords; same packing.
- busy  out  1  high in DRAIN, COPY and DONE.
- done  out  1  one-cycle pulse in DONE.
- loaded  out  3  per channel {phase,offset,amp}; all 64 words received since the last commit.
- overflow  out  3  sticky per channel; a word was dropped.

## Operation
- Channel index: amp=0, offset=1, phase=2. Shadow address = {chan[1:0], idx[5:0]}, which gives 0..191 in use.
- Each channel has a 16-bit hold register, a hold_valid bit and a 6-bit idx counter.
- Capture rule, on a strobe at cycle t:
  - If hold_valid=0, or the channel is granted in cycle t, the word loads into hold and hold_valid is 1 after the edge.
  - Otherwise the word is dropped and overflow[chan] sets. It stays set until reset.
- Arbiter: active in IDLE and DRAIN only.
  - Grants at most one channel per cycle among those with hold_valid=1.
  - Round-robin order 0->1->2->0. The pointer moves to the channel after the one granted.
  - The pointer resets to 0.
- Grant effects on channel c, at the edge:
  - shadow[{c,idx_c}] <= hold_c, and idx_c increments.
  - hold_valid_c clears unless a new word is captured in the same cycle.
  - When idx_c goes from 63 to 0, loaded[c] sets.
  - idx wraps modulo 64, so later words overwrite from slot 0.
- FSM states: IDLE, DRAIN, COPY, DONE.
  - IDLE: commit=1 -> DRAIN.
  - DRAIN: when all three hold_valid are 0 -> COPY, with copy address 0.
  - COPY: each cycle, active word[addr] <= shadow[addr]. Addresses 0..63 go to amps, 64..127 to offsets, 128..191 to phasewords. addr increments. After addr 191 -> DONE.
  - DONE: done=1; all idx and loaded clear to 0 -> IDLE.
- No grants in COPY or DONE. Pipe words arriving then fill hold once per channel; further words overflow.
- commit outside IDLE is ignored. commit held high re-triggers in the IDLE cycle after DONE.
- Active buses change word-by-word during COPY. The downstream bank must be held in reset while busy=1.

## Timing
- Reset values:
  - amps/offsets/phasewords = 0.
  - busy = done = 0; loaded = overflow = 0.
  - FSM = IDLE; all idx, hold_valid and the RR pointer = 0.
  - The shadow store is not required to reset.
- Write latency: a strobe at t is in hold at t+1. Its earliest grant is t+1, so the shadow is written at the end of t+1.
- Throughput: 1 shadow write per cycle total across channels. One strobing channel sustains 1 word/cycle with no overflow.
- Commit latency, with empty holds: commit at t gives DRAIN at t+1 and COPY at t+2..t+193. DONE is t+194 (done=1) and IDLE is t+195. busy=1 for t+1..t+194.
- DRAIN with k pending holds lasts k+1 cycles at most (≤4).
- Reset asserted mid-COPY: outputs clear immediately (asynchronous) and no done pulse is issued.
- Simultaneous strobe and grant on one channel in IDLE/DRAIN: the old hold goes to the shadow and the new word enters hold. No overflow.

## Test plan
- Reset, then stream amp words 0x1000+k for k=0..63 back-to-back, then commit. Required: loaded=001, busy for 194 cycles, one done pulse, amps[16k+:16]=0x1000+k, offsets and phasewords still 0.
- Strobe all three channels in the same cycle with 0xAAAA/0xBBBB/0xCCCC, once. Required: shadow written in order amp, offset, phase over 3 consecutive cycles; no overflow.
- Strobe all three channels every cycle for 4 cycles. Required: overflow bits set per the round-robin capture rule. Expected value 3'b111 is to be checked against a reference model.
- Write 65 offset words 0..64, then commit. Required: offsets word0=64, word1=1; loaded[1]=1 before commit and 0 after done.
- Assert commit, then strobe phase_write 3 times during COPY. Required: first word held, overflow[2]=1. That held word is granted after IDLE and lands at phase idx 0.
- Assert reset at COPY addr 100. Required: all buses 0 and busy=0 immediately; done never pulses; a subsequent commit works normally.

Source files
------------

// File: rtl/wave_param_loader.sv
// rtl/wave_param_loader.sv - three-pipe parameter loader with round-robin shadow store and commit copy
module wave_param_loader (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_amp_write,
    input  logic [15:0]   i_amp_data,
    input  logic          i_offset_write,
    input  logic [15:0]   i_offset_data,
    input  logic          i_phase_write,
    input  logic [15:0]   i_phase_data,
    input  logic          i_commit,
    output logic [1023:0] o_amps,
    output logic [1023:0] o_offsets,
    output logic [1023:0] o_phasewords,
    output logic          o_busy,
    output logic          o_done,
    output logic [2:0]    o_loaded,
    output logic [2:0]    o_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COPY, S_DONE} state_t;

    state_t           r_state;
    logic [1:0]       r_rr;
    logic [2:0][15:0] r_hold;
    logic [2:0]       r_hold_valid;
    logic [2:0][5:0]  r_idx;
    logic [7:0]       r_addr;
    logic [15:0]      r_shadow [0:191];

    logic [2:0]       w_strobe;
    logic [2:0][15:0] w_data;
    logic             w_gnt_valid;
    logic [1:0]       w_gnt_chan;
    logic [2:0]       w_gnt_onehot;
    logic [2:0]       w_sum;
    logic [1:0]       w_cand;
    logic [15:0]      w_rd_word;
    logic [9:0]       w_bit_base;

    assign w_strobe   = {i_phase_write, i_offset_write, i_amp_write};
    assign w_data     = {i_phase_data, i_offset_data, i_amp_data};
    assign w_rd_word  = r_shadow[r_addr];
    assign w_bit_base = {r_addr[5:0], 4'd0};

    // Round-robin search starting at r_rr; only IDLE and DRAIN may grant.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_chan  = 2'd0;
        w_sum       = 3'd0;
        w_cand      = 2'd0;
        if (r_state == S_IDLE || r_state == S_DRAIN) begin
            for (int i = 0; i < 3; i++) begin
                w_sum  = {1'b0, r_rr} + 3'(i);
                w_cand = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
                if (!w_gnt_valid && r_hold_valid[w_cand]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_chan  = w_cand;
                end
            end
        end
    end

    assign w_gnt_onehot = w_gnt_valid ? (3'b001 << w_gnt_chan) : 3'b000;

    always_ff @(posedge i_clk) begin
        if (w_gnt_valid)
            r_shadow[{w_gnt_chan, r_idx[w_gnt_chan]}] <= r_hold[w_gnt_chan];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_rr         <= 2'd0;
            r_hold       <= '0;
            r_hold_valid <= 3'b000;
            r_idx        <= '0;
            r_addr       <= 8'd0;
            o_amps       <= '0;
            o_offsets    <= '0;
            o_phasewords <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_loaded     <= 3'b000;
            o_overflow   <= 3'b000;
        end else begin
            if (w_gnt_valid)
                r_rr <= (w_gnt_chan == 2'd2) ? 2'd0 : w_gnt_chan + 2'd1;

            for (int c = 0; c < 3; c++) begin
                if (w_gnt_onehot[c]) begin
                    r_idx[c] <= r_idx[c] + 6'd1;
                    if (r_idx[c] == 6'd63)
                        o_loaded[c] <= 1'b1;
                end
                // A granted hold frees its slot in the same cycle, so a fresh word is not dropped.
                if (w_strobe[c] && (!r_hold_valid[c] || w_gnt_onehot[c])) begin
                    r_hold[c]       <= w_data[c];
                    r_hold_valid[c] <= 1'b1;
                end else if (w_strobe[c]) begin
                    o_overflow[c] <= 1'b1;
                end else if (w_gnt_onehot[c]) begin
                    r_hold_valid[c] <= 1'b0;
                end
            end

            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_commit) begin
                        r_state <= S_DRAIN;
                        o_busy  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_hold_valid == 3'b000) begin
                        r_state <= S_COPY;
                        r_addr  <= 8'd0;
                    end
                end
                S_COPY: begin
                    case (r_addr[7:6])
                        2'd0:    o_amps[w_bit_base +: 16]       <= w_rd_word;
                        2'd1:    o_offsets[w_bit_base +: 16]    <= w_rd_word;
                        2'd2:    o_phasewords[w_bit_base +: 16] <= w_rd_word;
                        default: ;
                    endcase
                    r_addr <= r_addr + 8'd1;
                    if (r_addr == 8'd191) begin
                        r_state <= S_DONE;
                        o_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    o_busy   <= 1'b0;
                    r_idx    <= '0;
                    o_loaded <= 3'b000;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
